dmem_access_ctrl: RTL and testbench

//  Sequences every data-memory access for the MEM stage and shares the data

---
 rtl/dmem_access_ctrl.sv | 140 ++++++++++++++
 tb/tb_dmem_access_ctrl.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/dmem_access_ctrl.sv
// Data-memory access sequencer for the MEM stage: arbitrates the CPU port and the
// loader port, drives the memory strobes for WAIT_CYCLES+1 cycles and stalls the pipeline.
module dmem_access_ctrl #(
  parameter int unsigned WAIT_CYCLES = 1,
  parameter int unsigned MAX_STARVE  = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        cpu_rd,
  input  logic        cpu_wr,
  input  logic [31:0] cpu_addr,
  input  logic [31:0] cpu_wdata,
  output logic        cpu_stall,
  output logic [31:0] cpu_rdata,
  output logic        cpu_done,
  output logic        cpu_align_err,
  input  logic        ld_req,
  input  logic        ld_wr,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_wdata,
  output logic [31:0] ld_rdata,
  output logic        ld_done,
  output logic        mem_rd,
  output logic        mem_wr,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  localparam int SW = $clog2(MAX_STARVE + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_DONE} state_e;
  typedef enum logic {OWN_CPU, OWN_LD} owner_e;

  state_e        state_q, state_d;
  owner_e        owner_q, owner_d;
  logic          wr_q, wr_d;
  logic          err_q, err_d;
  logic [31:0]   addr_q, addr_d;
  logic [31:0]   wdata_q, wdata_d;
  logic [3:0]    cnt_q, cnt_d;
  logic [SW-1:0] starve_q, starve_d;
  logic [31:0]   cpu_rdata_q, cpu_rdata_d;
  logic [31:0]   ld_rdata_q, ld_rdata_d;

  logic cpu_req, starve_full, grant_cpu, grant_ld;

  assign cpu_req     = cpu_rd | cpu_wr;
  assign starve_full = (starve_q == SW'(MAX_STARVE));
  assign grant_cpu   = cpu_req & ~(ld_req & starve_full);
  assign grant_ld    = ~grant_cpu & ld_req;

  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    wr_d        = wr_q;
    err_d       = err_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    cnt_d       = cnt_q;
    starve_d    = starve_q;
    cpu_rdata_d = cpu_rdata_q;
    ld_rdata_d  = ld_rdata_q;
    case (state_q)
      S_IDLE: begin
        if (!ld_req || grant_ld)           starve_d = '0;
        else if (grant_cpu && !starve_full) starve_d = starve_q + SW'(1);
        if (grant_cpu) begin
          state_d = S_ACCESS;
          owner_d = OWN_CPU;
          wr_d    = cpu_wr;
          addr_d  = cpu_addr;
          wdata_d = cpu_wdata;
          err_d   = |cpu_addr[1:0];
          cnt_d   = 4'(WAIT_CYCLES);
        end else if (grant_ld) begin
          state_d = S_ACCESS;
          owner_d = OWN_LD;
          wr_d    = ld_wr;
          addr_d  = ld_addr & ~32'h3;  // loader byte offset is ignored
          wdata_d = ld_wdata;
          err_d   = 1'b0;
          cnt_d   = 4'(WAIT_CYCLES);
        end
      end
      S_ACCESS: begin
        if (cnt_q == 4'd0) begin
          state_d = S_DONE;
          if (!err_q && !wr_q) begin
            if (owner_q == OWN_CPU) cpu_rdata_d = mem_rdata;
            else                    ld_rdata_d  = mem_rdata;
          end
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      owner_q     <= OWN_CPU;
      wr_q        <= 1'b0;
      err_q       <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      cnt_q       <= '0;
      starve_q    <= '0;
      cpu_rdata_q <= '0;
      ld_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      wr_q        <= wr_d;
      err_q       <= err_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      cnt_q       <= cnt_d;
      starve_q    <= starve_d;
      cpu_rdata_q <= cpu_rdata_d;
      ld_rdata_q  <= ld_rdata_d;
    end
  end

  // Strobes decode straight from state so an async reset drops them immediately.
  assign mem_rd        = (state_q == S_ACCESS) & ~wr_q & ~err_q;
  assign mem_wr        = (state_q == S_ACCESS) &  wr_q & ~err_q;
  assign mem_addr      = addr_q;
  assign mem_wdata     = wdata_q;
  assign cpu_done      = (state_q == S_DONE) & (owner_q == OWN_CPU);
  assign cpu_align_err = cpu_done & err_q;
  assign ld_done       = (state_q == S_DONE) & (owner_q == OWN_LD);
  assign cpu_stall     = cpu_req & ~cpu_done;
  assign cpu_rdata     = cpu_rdata_q;
  assign ld_rdata      = ld_rdata_q;

endmodule

// File: tb/tb_dmem_access_ctrl.sv
// Directed bench for dmem_access_ctrl (WAIT_CYCLES=1, MAX_STARVE=4) with a small
// word-addressed memory model behind the mem_* port.
module tb_dmem_access_ctrl;
  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        cpu_rd = 1'b0, cpu_wr = 1'b0;
  logic [31:0] cpu_addr = '0, cpu_wdata = '0;
  logic        cpu_stall, cpu_done, cpu_align_err;
  logic [31:0] cpu_rdata;
  logic        ld_req = 1'b0, ld_wr = 1'b0;
  logic [31:0] ld_addr = '0, ld_wdata = '0;
  logic [31:0] ld_rdata;
  logic        ld_done;
  logic        mem_rd, mem_wr;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  dmem_access_ctrl #(.WAIT_CYCLES(W), .MAX_STARVE(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .cpu_rd(cpu_rd), .cpu_wr(cpu_wr), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_stall(cpu_stall), .cpu_rdata(cpu_rdata), .cpu_done(cpu_done),
    .cpu_align_err(cpu_align_err),
    .ld_req(ld_req), .ld_wr(ld_wr), .ld_addr(ld_addr), .ld_wdata(ld_wdata),
    .ld_rdata(ld_rdata), .ld_done(ld_done),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  // Memory model; the preload path shares the write port with the DUT.
  logic [31:0] mem [0:255];
  logic        pre_we = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_dat = '0;
  assign mem_rdata = mem[mem_addr[9:2]];
  always @(posedge clk) begin
    if (pre_we)      mem[pre_idx] <= pre_dat;
    else if (mem_wr) mem[mem_addr[9:2]] <= mem_wdata;
  end

  int cyc_cnt = 0;
  int ld_pulses = 0;
  always @(posedge clk) cyc_cnt <= cyc_cnt + 1;
  always @(negedge clk) if (ld_done) ld_pulses <= ld_pulses + 1;

  int pass_cnt = 0, total_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic preload(input logic [7:0] idx, input logic [31:0] dat);
    @(negedge clk);
    pre_we = 1'b1; pre_idx = idx; pre_dat = dat;
    @(negedge clk);
    pre_we = 1'b0;
  endtask

  // Called at a negedge; presents the request and holds it until cpu_done.
  task automatic cpu_access(input logic rd, input logic wr, input logic [31:0] addr,
                            input logic [31:0] wdata, output int done_cyc,
                            output int rd_n, output int wr_n, output int st_n,
                            output logic [31:0] rdata, output logic err);
    done_cyc = -1; rd_n = 0; wr_n = 0; st_n = 0; rdata = '0; err = 1'b0;
    cpu_rd = rd; cpu_wr = wr; cpu_addr = addr; cpu_wdata = wdata;
    for (int c = 0; c < 40; c++) begin
      #1;
      if (mem_rd)    rd_n++;
      if (mem_wr)    wr_n++;
      if (cpu_stall) st_n++;
      if (cpu_done) begin
        done_cyc = c; rdata = cpu_rdata; err = cpu_align_err;
        break;
      end
      @(negedge clk);
    end
    @(negedge clk);
    cpu_rd = 1'b0; cpu_wr = 1'b0;
  endtask

  typedef struct {
    string       name;
    logic        rd, wr;
    logic [31:0] addr, wdata, exp_rdata;
    logic        exp_err;
    int          exp_rd, exp_wr;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int dc, rn, wn, sn, cpu_served, ld_at, cpu_at;
    logic [31:0] rdv, ldv;
    logic er, seen;

    vecs[0] = '{"lw_0x10",    1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, W+1, 0};
    vecs[1] = '{"sw_0x20",    0, 1, 32'h20, 32'h12345678, 32'h0, 0, 0, W+1};
    vecs[2] = '{"lw_0x20",    1, 0, 32'h20, 32'h0, 32'h12345678, 0, W+1, 0};
    vecs[3] = '{"lw_mis_0x22",1, 0, 32'h22, 32'h0, 32'h0, 1, 0, 0};
    vecs[4] = '{"sw_mis_0x31",0, 1, 32'h31, 32'hFFFFFFFF, 32'h0, 1, 0, 0};
    vecs[5] = '{"lw_0x30",    1, 0, 32'h30, 32'h0, 32'hA5A5A5A5, 0, W+1, 0};
    vecs[6] = '{"lw_0x10_b",  1, 0, 32'h10, 32'h0, 32'hDEADBEEF, 0, W+1, 0};

    // Reset state, with a CPU request showing through to cpu_stall.
    cpu_rd = 1'b1;
    #12;
    chk("rst_stall_follows_req", {31'd0, cpu_stall}, 32'd1);
    cpu_rd = 1'b0;
    #1;
    chk("rst_stall_idle", {31'd0, cpu_stall}, 32'd0);
    chk("rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("rst_mem_wr", {31'd0, mem_wr}, 32'd0);
    chk("rst_cpu_done", {31'd0, cpu_done}, 32'd0);
    chk("rst_ld_done", {31'd0, ld_done}, 32'd0);
    chk("rst_align_err", {31'd0, cpu_align_err}, 32'd0);
    chk("rst_mem_addr", mem_addr, 32'h0);
    chk("rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("rst_ld_rdata", ld_rdata, 32'h0);

    preload(8'd4,  32'hDEADBEEF);
    preload(8'd12, 32'hA5A5A5A5);
    preload(8'd17, 32'h0BADF00D);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Table: done in the 4th cycle (index W+2), stall for W+2 cycles.
    for (int i = 0; i < 7; i++) begin
      cpu_access(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, dc, rn, wn, sn, rdv, er);
      chk({vecs[i].name, "_done_cyc"}, dc, W + 2);
      chk({vecs[i].name, "_stall_cyc"}, sn, W + 2);
      chk({vecs[i].name, "_rd_cyc"}, rn, vecs[i].exp_rd);
      chk({vecs[i].name, "_wr_cyc"}, wn, vecs[i].exp_wr);
      chk({vecs[i].name, "_err"}, {31'd0, er}, {31'd0, vecs[i].exp_err});
      if (vecs[i].rd && !vecs[i].exp_err)
        chk({vecs[i].name, "_rdata"}, rdv, vecs[i].exp_rdata);
    end

    // Starvation guard: 4 CPU grants, then the loader.
    cpu_served = 0; ld_at = -1; ldv = '0;
    ld_pulses = 0;
    ld_req = 1'b1; ld_wr = 1'b0; ld_addr = 32'h47;
    fork
      begin
        for (int k = 0; k < 5; k++) begin
          cpu_access(1'b1, 1'b0, 32'h10, 32'h0, dc, rn, wn, sn, rdv, er);
          if (dc >= 0) cpu_served++;
        end
      end
      begin
        for (int c = 0; c < 80; c++) begin
          @(negedge clk); #1;
          if (ld_done) begin ld_at = cpu_served; ldv = ld_rdata; ld_req = 1'b0; break; end
        end
        ld_req = 1'b0;
      end
    join
    chk("starve_cpu_before_ld", ld_at, 4);
    chk("starve_cpu_total", cpu_served, 5);
    chk("starve_ld_rdata", ldv, 32'h0BADF00D);
    chk("starve_ld_pulses", ld_pulses, 1);
    chk("starve_last_cpu_rdata", rdv, 32'hDEADBEEF);

    // Simultaneous CPU store and LD write with a clear starvation counter.
    @(negedge clk);
    cpu_at = -1; ld_at = -1;
    ld_req = 1'b1; ld_wr = 1'b1; ld_addr = 32'h54; ld_wdata = 32'h11112222;
    fork
      begin
        cpu_access(1'b0, 1'b1, 32'h50, 32'hCAFEF00D, dc, rn, wn, sn, rdv, er);
        cpu_at = cyc_cnt;
      end
      begin
        for (int c = 0; c < 60; c++) begin
          @(negedge clk); #1;
          if (ld_done) begin ld_at = cyc_cnt; ld_req = 1'b0; break; end
        end
        ld_req = 1'b0;
      end
    join
    chk("simul_cpu_first_cyc", dc, W + 2);
    chk("simul_ld_after_cpu", {31'd0, (ld_at > cpu_at) && (cpu_at >= 0)}, 32'd1);
    cpu_access(1'b1, 1'b0, 32'h54, 32'h0, dc, rn, wn, sn, rdv, er);
    chk("simul_ld_write_data", rdv, 32'h11112222);
    cpu_access(1'b1, 1'b0, 32'h50, 32'h0, dc, rn, wn, sn, rdv, er);
    chk("simul_cpu_write_data", rdv, 32'hCAFEF00D);

    // Request dropped mid-access still completes.
    cpu_rd = 1'b1; cpu_addr = 32'h30;
    @(negedge clk);
    cpu_rd = 1'b0;
    #1;
    chk("drop_stall_low", {31'd0, cpu_stall}, 32'd0);
    seen = 1'b0;
    for (int c = 0; c < 10; c++) begin
      if (cpu_done) begin seen = 1'b1; rdv = cpu_rdata; break; end
      @(negedge clk); #1;
    end
    chk("drop_done_seen", {31'd0, seen}, 32'd1);
    chk("drop_rdata", rdv, 32'hA5A5A5A5);

    // Asynchronous reset in the middle of ACCESS.
    @(negedge clk);
    cpu_rd = 1'b1; cpu_addr = 32'h10;
    @(negedge clk); #1;
    chk("mid_rst_pre_mem_rd", {31'd0, mem_rd}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_mem_rd", {31'd0, mem_rd}, 32'd0);
    chk("mid_rst_mem_addr", mem_addr, 32'h0);
    chk("mid_rst_cpu_rdata", cpu_rdata, 32'h0);
    chk("mid_rst_stall", {31'd0, cpu_stall}, 32'd1);
    cpu_rd = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    cpu_access(1'b1, 1'b0, 32'h10, 32'h0, dc, rn, wn, sn, rdv, er);
    chk("post_rst_done_cyc", dc, W + 2);
    chk("post_rst_rdata", rdv, 32'hDEADBEEF);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish, passed %0d of %0d", pass_cnt, total_cnt);
    $fatal(1);
  end
endmodule
